dmem_controller: RTL and testbench
==================================

# dmem_controller

Arbitrating data-memory controller between the per-thread load/store units (consumers) inside the GPU cores and the external data-memory channels. It multiplexes NUM_CONSUMERS independent valid/ready read and write requests onto NUM_CHANNELS memory channels and relays read data and write acknowledgements back to the requester. It sits directly upstream of the `data_mem_*` ports at the GPU top level, which connect to the external data memory.

## Interface
- ADDR_BITS, 8, data-memory address width
- DATA_BITS, 8, data word width
- NUM_CONSUMERS, 8, LSU request ports (NUM_CORES × THREADS_PER_BLOCK)
- NUM_CHANNELS, 2, memory channels; 1 ≤ NUM_CHANNELS ≤ NUM_CONSUMERS
- clk  input  1  sole clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- consumer_read_valid  input  [NUM_CONSUMERS]  read request
- consumer_read_address  input  [NUM_CONSUMERS] × ADDR_BITS  read address
- consumer_read_ready  output  [NUM_CONSUMERS]  read data valid, held until the request is dropped
- consumer_read_data  output  [NUM_CONSUMERS] × DATA_BITS  returned word
- consumer_write_valid  input  [NUM_CONSUMERS]  write request
- consumer_write_address  input  [NUM_CONSUMERS] × ADDR_BITS
- consumer_write_data  input  [NUM_CONSUMERS] × DATA_BITS
- consumer_write_ready  output  [NUM_CONSUMERS]  write done, held until the request is dropped
- mem_read_valid  output  [NUM_CHANNELS]
- mem_read_address  output  [NUM_CHANNELS] × ADDR_BITS
- mem_read_ready  input  [NUM_CHANNELS]  single-cycle pulse; data valid in the same cycle
- mem_read_data  input  [NUM_CHANNELS] × DATA_BITS
- mem_write_valid  output  [NUM_CHANNELS]
- mem_write_address  output  [NUM_CHANNELS] × ADDR_BITS
- mem_write_data  output  [NUM_CHANNELS] × DATA_BITS
- mem_write_ready  input  [NUM_CHANNELS]  single-cycle pulse

## Operation
- One FSM per channel, with states IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- Each consumer has a busy bit, which is set while that consumer is owned by a channel.
- **IDLE:** the channel scans consumers from index 0 upward and takes the lowest-indexed consumer whose busy bit is clear and which has read_valid or write_valid set.
  - A consumer must never assert read_valid and write_valid together. If both are set anyway, the read is taken.
  - Channels are evaluated in index order within the same cycle. A consumer claimed by channel c is invisible to channels > c in that cycle, so no consumer is ever served twice.
  - On a grant:
    - Register the address (and write data, for writes).
    - Assert mem_read_valid or mem_write_valid.
    - Set the busy bit.
    - Go to READ_WAIT or WRITE_WAIT.
- **READ_WAIT:** hold valid and address stable until mem_read_ready = 1. On that edge:
  - capture mem_read_data into consumer_read_data[owner];
  - set consumer_read_ready[owner];
  - clear mem_read_valid;
  - go to RELAY.
- **WRITE_WAIT:** same as READ_WAIT, using mem_write_ready. On that edge, set consumer_write_ready[owner], clear mem_write_valid, go to RELAY.
- **RELAY:** hold the ready bit until the owner's corresponding valid is sampled low. Then:
  - clear the ready bit;
  - clear the busy bit;
  - go to IDLE.
- consumer_read_data[i] retains its last captured value.
- Reset (asynchronous, any state, including mid-transaction):
  - all FSMs return to IDLE;
  - all busy bits clear;
  - all valid and ready outputs go to 0;
  - all address and data outputs go to 0.
  - An in-flight memory transaction is abandoned. A mem ready pulse arriving after reset is ignored.
- A ready pulse on a channel that is in IDLE or RELAY is ignored.

## Timing
- Request visible at edge k → mem_*_valid high after edge k (visible from cycle k+1).
- Memory ready pulse at edge m → consumer ready and data valid after m, and mem_*_valid low after m.
  - Total controller overhead: 2 cycles plus the memory latency.
- Consumer drops valid, sampled at edge r → consumer ready low after r; the channel is IDLE after r.
  - The channel can grant again at edge r+1.
- With more outstanding requesters than channels, the excess wait in request order by index. Lowest index wins; there is no fairness guarantee beyond this.
- No combinational path from any input to any output. All outputs are registered.

## Test plan
- **Single read.** Consumer 3 reads address 0x05 (memory = 7, 5-cycle memory latency).
  - mem_read_valid[0] rises 1 cycle after the request, with address 0x05.
  - consumer_read_ready[3] rises 1 cycle after the memory pulse, with data = 7.
  - The ready bit clears 1 cycle after valid drops.
- **Parallel reads.** Consumers 0 and 1 request in the same cycle.
  - Channel 0 serves consumer 0 and channel 1 serves consumer 1, concurrently.
  - Both complete in the same cycle.
- **Oversubscription.** Consumers 0, 2 and 5 read together with 2 channels.
  - Consumers 0 and 2 are granted first.
  - Consumer 5 is granted only after a channel returns to IDLE.
  - No consumer is served twice.
- **Write.** Consumer 4 writes 0x1A to address 20.
  - mem_write_* carry address 20 and data 0x1A until the memory pulse.
  - consumer_write_ready[4] then asserts.
  - The memory model holds 0x1A at address 20.
- **Mixed.** Consumer 1 reads while consumer 6 writes, using an 8-thread matmul-style address pattern.
  - Every read returns the model value.
  - Every write lands exactly once.
- **Reset mid-operation.** Assert reset during READ_WAIT.
  - All outputs go to 0 immediately.
  - A later memory pulse is ignored.
  - After release, a fresh request completes normally.

Source files
------------

// File: rtl/dmem_controller.sv
// Arbitrates NUM_CONSUMERS read/write requesters onto NUM_CHANNELS memory channels.
// Latency: grant 1 cycle after request, consumer ready 1 cycle after the memory pulse.
// Backpressure: a requester is held off until a channel is IDLE; lowest index wins.
module dmem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                                     clk,
    input  logic                                     reset,

    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,

    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

    localparam int OWN_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_READ_WAIT  = 2'd1,
        S_WRITE_WAIT = 2'd2,
        S_RELAY      = 2'd3
    } state_t;

    state_t                                   state_q [NUM_CHANNELS];
    state_t                                   state_d [NUM_CHANNELS];
    logic [OWN_W-1:0]                         owner_q [NUM_CHANNELS];
    logic [OWN_W-1:0]                         owner_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]                  is_wr_q, is_wr_d;
    logic [NUM_CONSUMERS-1:0]                 busy_q, busy_d;

    logic [NUM_CHANNELS-1:0]                  mem_read_valid_q, mem_read_valid_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address_q, mem_read_address_d;
    logic [NUM_CHANNELS-1:0]                  mem_write_valid_q, mem_write_valid_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address_q, mem_write_address_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]                 consumer_read_ready_q, consumer_read_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data_q, consumer_read_data_d;
    logic [NUM_CONSUMERS-1:0]                 consumer_write_ready_q, consumer_write_ready_d;

    // Grant scan scratch: claim accumulates consumers taken by lower channels this cycle.
    logic [NUM_CONSUMERS-1:0]                 claim;
    logic                                     found;
    logic [OWN_W-1:0]                         sel;
    logic                                     sel_wr;

    // Per-channel next state, evaluated in channel order so claims are visible downstream.
    always_comb begin
        state_d                = state_q;
        owner_d                = owner_q;
        is_wr_d                = is_wr_q;
        busy_d                 = busy_q;
        mem_read_valid_d       = mem_read_valid_q;
        mem_read_address_d     = mem_read_address_q;
        mem_write_valid_d      = mem_write_valid_q;
        mem_write_address_d    = mem_write_address_q;
        mem_write_data_d       = mem_write_data_q;
        consumer_read_ready_d  = consumer_read_ready_q;
        consumer_read_data_d   = consumer_read_data_q;
        consumer_write_ready_d = consumer_write_ready_q;
        claim                  = busy_q;
        found                  = 1'b0;
        sel                    = '0;
        sel_wr                 = 1'b0;

        for (int c = 0; c < NUM_CHANNELS; c++) begin
            found  = 1'b0;
            sel    = '0;
            sel_wr = 1'b0;
            case (state_q[c])
                S_IDLE: begin
                    for (int i = 0; i < NUM_CONSUMERS; i++) begin
                        if (!found && !claim[i] &&
                            (consumer_read_valid[i] || consumer_write_valid[i])) begin
                            found  = 1'b1;
                            sel    = OWN_W'(i);
                            // A read wins if a consumer illegally raises both.
                            sel_wr = !consumer_read_valid[i];
                        end
                    end
                    if (found) begin
                        claim[sel]  = 1'b1;
                        busy_d[sel] = 1'b1;
                        owner_d[c]  = sel;
                        is_wr_d[c]  = sel_wr;
                        if (sel_wr) begin
                            mem_write_valid_d[c]   = 1'b1;
                            mem_write_address_d[c] = consumer_write_address[sel];
                            mem_write_data_d[c]    = consumer_write_data[sel];
                            state_d[c]             = S_WRITE_WAIT;
                        end else begin
                            mem_read_valid_d[c]    = 1'b1;
                            mem_read_address_d[c]  = consumer_read_address[sel];
                            state_d[c]             = S_READ_WAIT;
                        end
                    end
                end
                S_READ_WAIT: begin
                    if (mem_read_ready[c]) begin
                        consumer_read_data_d[owner_q[c]]  = mem_read_data[c];
                        consumer_read_ready_d[owner_q[c]] = 1'b1;
                        mem_read_valid_d[c]               = 1'b0;
                        state_d[c]                        = S_RELAY;
                    end
                end
                S_WRITE_WAIT: begin
                    if (mem_write_ready[c]) begin
                        consumer_write_ready_d[owner_q[c]] = 1'b1;
                        mem_write_valid_d[c]               = 1'b0;
                        state_d[c]                         = S_RELAY;
                    end
                end
                default: begin
                    // Hold the handshake until the owner withdraws its request.
                    if (is_wr_q[c] ? !consumer_write_valid[owner_q[c]]
                                   : !consumer_read_valid[owner_q[c]]) begin
                        consumer_read_ready_d[owner_q[c]]  = 1'b0;
                        consumer_write_ready_d[owner_q[c]] = 1'b0;
                        busy_d[owner_q[c]]                 = 1'b0;
                        state_d[c]                         = S_IDLE;
                    end
                end
            endcase
        end
    end

    // State and output registers; reset abandons any in-flight memory access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= S_IDLE;
                owner_q[c] <= '0;
            end
            is_wr_q                <= '0;
            busy_q                 <= '0;
            mem_read_valid_q       <= '0;
            mem_read_address_q     <= '0;
            mem_write_valid_q      <= '0;
            mem_write_address_q    <= '0;
            mem_write_data_q       <= '0;
            consumer_read_ready_q  <= '0;
            consumer_read_data_q   <= '0;
            consumer_write_ready_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                owner_q[c] <= owner_d[c];
            end
            is_wr_q                <= is_wr_d;
            busy_q                 <= busy_d;
            mem_read_valid_q       <= mem_read_valid_d;
            mem_read_address_q     <= mem_read_address_d;
            mem_write_valid_q      <= mem_write_valid_d;
            mem_write_address_q    <= mem_write_address_d;
            mem_write_data_q       <= mem_write_data_d;
            consumer_read_ready_q  <= consumer_read_ready_d;
            consumer_read_data_q   <= consumer_read_data_d;
            consumer_write_ready_q <= consumer_write_ready_d;
        end
    end

    assign mem_read_valid       = mem_read_valid_q;
    assign mem_read_address     = mem_read_address_q;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;
    assign consumer_read_ready  = consumer_read_ready_q;
    assign consumer_read_data   = consumer_read_data_q;
    assign consumer_write_ready = consumer_write_ready_q;

endmodule

// File: tb/tb_dmem_controller.sv
// Bench for dmem_controller: directed scenarios, then random traffic.
// A memory responder with configurable latency feeds the channels.
// A cycle model of the arbitration rules is compared on every falling edge.
module tb_dmem_controller;

    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int NC  = 8;
    localparam int NCH = 2;

    logic clk;
    logic reset;
    logic [NC-1:0]            consumer_read_valid;
    logic [NC-1:0][AB-1:0]    consumer_read_address;
    logic [NC-1:0]            consumer_read_ready;
    logic [NC-1:0][DB-1:0]    consumer_read_data;
    logic [NC-1:0]            consumer_write_valid;
    logic [NC-1:0][AB-1:0]    consumer_write_address;
    logic [NC-1:0][DB-1:0]    consumer_write_data;
    logic [NC-1:0]            consumer_write_ready;
    logic [NCH-1:0]           mem_read_valid;
    logic [NCH-1:0][AB-1:0]   mem_read_address;
    logic [NCH-1:0]           mem_read_ready;
    logic [NCH-1:0][DB-1:0]   mem_read_data;
    logic [NCH-1:0]           mem_write_valid;
    logic [NCH-1:0][AB-1:0]   mem_write_address;
    logic [NCH-1:0][DB-1:0]   mem_write_data;
    logic [NCH-1:0]           mem_write_ready;

    dmem_controller #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NCH)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    // Memory responder controls and bookkeeping.
    logic [DB-1:0]  mem_arr [256];
    bit             rand_lat = 1'b0;
    bit [NCH-1:0]   stray = '0;
    int             n_wr_mem = 0;

    // Driver-side bookkeeping.
    int             done_cyc [NC];
    logic [DB-1:0]  rd_cap   [NC];
    int             st       [NC];
    bit             op_wr    [NC];
    int             n_req = 0, n_done = 0, n_wr_done = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1);
    end

    function automatic logic [DB-1:0] memf(input int a);
        if (a == 5) return DB'(7);
        return DB'(a * 29 + 11);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: after the valid has been seen for 'lat' cycles, pulse ready once.
    initial begin : responder
        int cnt [NCH];
        int lat [NCH];
        for (int a = 0; a < 256; a++) mem_arr[a] = memf(a);
        for (int c = 0; c < NCH; c++) begin cnt[c] = 0; lat[c] = 5; end
        mem_read_ready  = '0;
        mem_write_ready = '0;
        mem_read_data   = '0;
        forever begin
            tick();
            for (int c = 0; c < NCH; c++) begin
                mem_read_ready[c]  = 1'b0;
                mem_write_ready[c] = 1'b0;
                if (!reset) begin
                    cnt[c] = 0;
                end else if (stray[c]) begin
                    mem_read_ready[c] = 1'b1;
                    mem_read_data[c]  = DB'(8'hEE);
                end else if (mem_read_valid[c] || mem_write_valid[c]) begin
                    cnt[c]++;
                    if (cnt[c] >= lat[c]) begin
                        cnt[c] = 0;
                        lat[c] = rand_lat ? int'($urandom_range(1, 4)) : 5;
                        if (mem_read_valid[c]) begin
                            mem_read_ready[c] = 1'b1;
                            mem_read_data[c]  = mem_arr[mem_read_address[c]];
                        end else begin
                            mem_write_ready[c] = 1'b1;
                            mem_arr[mem_write_address[c]] = mem_write_data[c];
                            n_wr_mem++;
                        end
                    end
                end
            end
        end
    end

    // Reference model: channels hold an owner (-1 when free) and are either waiting on
    // memory or relaying; predicted outputs are compared every falling edge.
    initial begin : model
        int                   m_own  [NCH];
        bit                   m_wait [NCH];
        bit                   m_wr   [NCH];
        bit                   taken  [NC];
        bit                   got;
        logic [NCH-1:0]           e_mrv, e_mwv;
        logic [NCH-1:0][AB-1:0]   e_mra, e_mwa;
        logic [NCH-1:0][DB-1:0]   e_mwd;
        logic [NC-1:0]            e_crr, e_cwr;
        logic [NC-1:0][DB-1:0]    e_crd;
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int c = 0; c < NCH; c++) begin m_own[c] = -1; m_wait[c] = 0; m_wr[c] = 0; end
                e_mrv = '0; e_mwv = '0; e_mra = '0; e_mwa = '0; e_mwd = '0;
                e_crr = '0; e_cwr = '0; e_crd = '0;
            end
            chk("mem_read_valid",       64'(mem_read_valid),       64'(e_mrv));
            chk("mem_read_address",     64'(mem_read_address),     64'(e_mra));
            chk("mem_write_valid",      64'(mem_write_valid),      64'(e_mwv));
            chk("mem_write_address",    64'(mem_write_address),    64'(e_mwa));
            chk("mem_write_data",       64'(mem_write_data),       64'(e_mwd));
            chk("consumer_read_ready",  64'(consumer_read_ready),  64'(e_crr));
            chk("consumer_read_data",   64'(consumer_read_data),   64'(e_crd));
            chk("consumer_write_ready", 64'(consumer_write_ready), 64'(e_cwr));
            if (reset) begin
                for (int i = 0; i < NC; i++) taken[i] = 0;
                for (int c = 0; c < NCH; c++) if (m_own[c] >= 0) taken[m_own[c]] = 1;
                for (int c = 0; c < NCH; c++) begin
                    if (m_own[c] < 0) begin
                        got = 0;
                        for (int i = 0; i < NC; i++) begin
                            if (!got && !taken[i] && (consumer_read_valid[i] || consumer_write_valid[i])) begin
                                got = 1; taken[i] = 1; m_own[c] = i; m_wait[c] = 1;
                                m_wr[c] = !consumer_read_valid[i];
                                if (m_wr[c]) begin
                                    e_mwv[c] = 1; e_mwa[c] = consumer_write_address[i];
                                    e_mwd[c] = consumer_write_data[i];
                                end else begin
                                    e_mrv[c] = 1; e_mra[c] = consumer_read_address[i];
                                end
                            end
                        end
                    end else if (m_wait[c]) begin
                        if (!m_wr[c] && mem_read_ready[c]) begin
                            e_crd[m_own[c]] = mem_read_data[c];
                            e_crr[m_own[c]] = 1; e_mrv[c] = 0; m_wait[c] = 0;
                        end else if (m_wr[c] && mem_write_ready[c]) begin
                            e_cwr[m_own[c]] = 1; e_mwv[c] = 0; m_wait[c] = 0;
                        end
                    end else if (m_wr[c] ? !consumer_write_valid[m_own[c]]
                                         : !consumer_read_valid[m_own[c]]) begin
                        e_crr[m_own[c]] = 0; e_cwr[m_own[c]] = 0; m_own[c] = -1;
                    end
                end
            end
        end
    end

    task automatic req_rd(input int i, input int a);
        consumer_read_valid[i]   = 1'b1;
        consumer_read_address[i] = AB'(a);
    endtask

    task automatic req_wr(input int i, input int a, input int d);
        consumer_write_valid[i]   = 1'b1;
        consumer_write_address[i] = AB'(a);
        consumer_write_data[i]    = DB'(d);
    endtask

    // Wait for every consumer in mask to see its ready, drop its valid, then idle one edge.
    task automatic run_until(input logic [NC-1:0] mask);
        int pend;
        for (int i = 0; i < NC; i++) done_cyc[i] = -1;
        pend = $countones(mask);
        for (int cyc = 1; cyc <= 200 && pend > 0; cyc++) begin
            tick();
            for (int i = 0; i < NC; i++) begin
                if (mask[i] && done_cyc[i] < 0 && (consumer_read_ready[i] || consumer_write_ready[i])) begin
                    done_cyc[i] = cyc;
                    rd_cap[i]   = consumer_read_data[i];
                    consumer_read_valid[i]  = 1'b0;
                    consumer_write_valid[i] = 1'b0;
                    pend--;
                end
            end
        end
        chk("run_timeout", 64'(pend), 64'd0);
        tick();
    endtask

    // One cycle of random consumer behaviour; new requests only when go is set.
    task automatic agent_step(input bit go);
        for (int i = 0; i < NC; i++) begin
            case (st[i])
                0: if (go && $urandom_range(0, 3) == 0) begin
                    op_wr[i] = bit'($urandom_range(0, 1));
                    if (op_wr[i]) req_wr(i, 128 + int'($urandom_range(0, 127)), int'($urandom_range(0, 255)));
                    else          req_rd(i, int'($urandom_range(0, 127)));
                    n_req++;
                    st[i] = 1;
                end
                1: if (op_wr[i] ? consumer_write_ready[i] : consumer_read_ready[i]) begin
                    n_done++;
                    if (op_wr[i]) n_wr_done++;
                    else chk("rand_rd_data", 64'(consumer_read_data[i]),
                             64'(mem_arr[consumer_read_address[i]]));
                    st[i] = 2;
                end
                2: if ($urandom_range(0, 1) == 1) begin
                    consumer_read_valid[i]  = 1'b0;
                    consumer_write_valid[i] = 1'b0;
                    st[i] = 3;
                end
                default: if (!consumer_read_ready[i] && !consumer_write_ready[i]) st[i] = 0;
            endcase
        end
    endtask

    initial begin : driver
        int base_wr;
        int busy_cnt;
        reset                  = 1'b0;
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        for (int i = 0; i < NC; i++) begin st[i] = 0; op_wr[i] = 0; rd_cap[i] = '0; end
        repeat (3) tick();
        chk("reset_mrv", 64'(mem_read_valid), 64'd0);
        chk("reset_crr", 64'(consumer_read_ready), 64'd0);
        reset = 1'b1;
        tick();

        // Single read: consumer 3, address 0x05, memory holds 7.
        req_rd(3, 5);
        tick();
        chk("single_mrv0", 64'(mem_read_valid), 64'd1);
        chk("single_addr", 64'(mem_read_address[0]), 64'h05);
        run_until(NC'(8'b0000_1000));
        chk("single_lat",  64'(done_cyc[3]), 64'd5);
        chk("single_data", 64'(rd_cap[3]), 64'd7);
        chk("single_clr",  64'(consumer_read_ready[3]), 64'd0);

        // Parallel reads on both channels.
        req_rd(0, 10);
        req_rd(1, 11);
        run_until(NC'(8'b0000_0011));
        chk("par_c0_lat", 64'(done_cyc[0]), 64'd6);
        chk("par_c1_lat", 64'(done_cyc[1]), 64'd6);
        chk("par_c1_data", 64'(rd_cap[1]), 64'(memf(11)));

        // Oversubscription: consumer 5 waits for a channel to return to IDLE.
        req_rd(0, 30);
        req_rd(2, 31);
        req_rd(5, 32);
        run_until(NC'(8'b0010_0101));
        chk("over_c0_lat", 64'(done_cyc[0]), 64'd6);
        chk("over_c2_lat", 64'(done_cyc[2]), 64'd6);
        chk("over_c5_lat", 64'(done_cyc[5]), 64'd13);
        chk("over_c5_data", 64'(rd_cap[5]), 64'(memf(32)));

        // Write: consumer 4 stores 0x1A at address 20.
        base_wr = n_wr_mem;
        req_wr(4, 20, 8'h1A);
        tick();
        chk("wr_valid", 64'(mem_write_valid), 64'd1);
        chk("wr_addr",  64'(mem_write_address[0]), 64'd20);
        tick();
        tick();
        chk("wr_hold_addr", 64'(mem_write_address[0]), 64'd20);
        chk("wr_hold_data", 64'(mem_write_data[0]), 64'h1A);
        run_until(NC'(8'b0001_0000));
        chk("wr_lat", 64'(done_cyc[4]), 64'd3);
        chk("wr_mem", 64'(mem_arr[20]), 64'h1A);

        // Mixed: consumer 1 streams A[k] while consumer 6 stores C[k].
        for (int k = 0; k < 8; k++) begin
            req_rd(1, k);
            req_wr(6, 128 + k, k * 3 + 1);
            run_until(NC'(8'b0100_0010));
            chk("mix_rd_data", 64'(rd_cap[1]), 64'(memf(k)));
        end
        for (int k = 0; k < 8; k++) chk("mix_wr_mem", 64'(mem_arr[128 + k]), 64'(k * 3 + 1));
        chk("mix_wr_once", 64'(n_wr_mem - base_wr), 64'd9);

        // Reset during READ_WAIT, then a stray pulse, then a fresh read.
        req_rd(3, 9);
        tick();
        tick();
        #1;
        reset = 1'b0;
        #1;
        chk("rst_mid_mrv",  64'(mem_read_valid), 64'd0);
        chk("rst_mid_addr", 64'(mem_read_address), 64'd0);
        chk("rst_mid_data", 64'(consumer_read_data), 64'd0);
        consumer_read_valid = '0;
        tick();
        tick();
        reset = 1'b1;
        stray = NCH'(1);
        tick();
        tick();
        stray = '0;
        tick();
        chk("stray_crr", 64'(consumer_read_ready), 64'd0);
        chk("stray_mrv", 64'(mem_read_valid), 64'd0);
        req_rd(3, 9);
        run_until(NC'(8'b0000_1000));
        chk("post_rst_lat",  64'(done_cyc[3]), 64'd6);
        chk("post_rst_data", 64'(rd_cap[3]), 64'(memf(9)));

        // Random traffic with random memory latency.
        rand_lat = 1'b1;
        base_wr  = n_wr_mem;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            agent_step(1'b1);
        end
        busy_cnt = NC;
        for (int cyc = 0; cyc < 400 && busy_cnt > 0; cyc++) begin
            tick();
            agent_step(1'b0);
            busy_cnt = 0;
            for (int i = 0; i < NC; i++) if (st[i] != 0) busy_cnt++;
        end
        chk("drain_timeout", 64'(busy_cnt), 64'd0);
        chk("rand_req_done", 64'(n_done), 64'(n_req));
        chk("rand_wr_once",  64'(n_wr_mem - base_wr), 64'(n_wr_done));
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
